gm_stream_server: RTL
=====================

Name: gm_stream_server

Overview:
- Holds the 16x16 Minesweeper game map: 256 cells, 4-bit cell codes.
- On each rising edge of the pixel generator's request, streams one board row (16 cells) to the pixel generator as GMaddress/GMdata beats.
- Sits between the game-logic write port and pixelgenerater, and also performs a bulk map clear for new games.

Parameters:
- COLS, 16, cells per row and beats per burst.
- ROWS, 16, rows per board; the row pointer wraps at ROWS.
- INIT_CODE, 4'h9, cell code written by clear (covered cell).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- request  in  1  from pixelgenerater; a rising edge asks for the next row.
- frame_start  in  1  one-cycle pulse at the start of a frame; rewinds the row pointer to 0.
- clr  in  1  one-cycle pulse; fills the whole map with INIT_CODE.
- wr_en  in  1  game-logic cell write strobe.
- wr_addr  in  8  cell address to write, {row[3:0], col[3:0]}.
- wr_data  in  4  cell code to write.
- GMaddress  out  8  streamed cell address, {row, col}.
- GMdata  out  4  streamed cell code.
- gm_valid  out  1  high while GMaddress/GMdata carry a beat.
- busy  out  1  high in STREAM or CLEAR.
- overrun  out  1  sticky; set when a request edge is dropped.
- clr_done  out  1  one-cycle pulse when a clear finishes.

Behaviour:
- Reset (rst_n low, async):
  - GMaddress=0, GMdata=0, gm_valid=0, busy=0, overrun=0, clr_done=0.
  - Row pointer=0, col counter=0, request history=0, FSM=IDLE.
  - Map RAM is not reset and is undefined until the first clear.
- Request edge: sampled as request & ~req_q, with req_q registered each cycle. A request held high never retriggers.
- FSM states: IDLE, STREAM, CLEAR. Priority order: clr > request edge > wr_en.
- IDLE:
  - clr -> CLEAR.
  - Request edge -> STREAM and beat 0 is issued at the same edge: GMaddress={row,0}, GMdata=mem[{row,0}], gm_valid=1.
- STREAM:
  - Beat k (k=0..15) is presented after edge n+k, where n is the detecting edge. There are exactly 16 consecutive valid cycles.
  - After edge n+16: gm_valid=0 and FSM=IDLE.
  - The row pointer advances (ROWS-1 wraps to 0), or goes to 0 if frame_start was seen during the burst.
  - A request edge at edge n+16 or later starts a new burst with no gap cycle required.
- Request edge while STREAM or CLEAR: dropped and overrun set to 1. overrun clears only on frame_start (or reset).
- frame_start:
  - In IDLE, the row pointer goes to 0 at that edge.
  - Coincident with a request edge, the burst streams row 0.
  - During STREAM, it is latched and applied at burst end.
  - It always clears overrun; a coincident drop leaves overrun=1.
- CLEAR:
  - Writes INIT_CODE to addresses 0..255, one per cycle, over 256 cycles. gm_valid=0 and busy=1 throughout.
  - clr during STREAM aborts the burst: gm_valid=0 after the same edge, with no row advance.
  - clr during CLEAR restarts the sweep at address 0.
  - At the end: clr_done pulses one cycle, row pointer=0, FSM=IDLE.
- Writes:
  - wr_en writes mem[wr_addr] in IDLE and STREAM.
  - wr_en is ignored in CLEAR and in any cycle where clr is high.
  - A write to the address being streamed in the same cycle is read-before-write: the beat shows the old code, and later bursts show the new code.
- Arithmetic: col and row are 4-bit wrapping counters. GMaddress is always {row, col}, never an out-of-range value.

Test Plan:
- Reset, clr, wait for clr_done (256 cycles after the clr edge) -> one pulse; a subsequent request edge streams 16 beats, GMaddress 0x00..0x0F, GMdata=9 each, gm_valid exactly 16 cycles.
- After clear, write mem[0x13]=4'h2 and mem[0x1F]=4'hB, then issue a second request edge -> row 1 burst, GMaddress 0x10..0x1F, GMdata 9 except 2 at beat 3 and B at beat 15.
- 17 request edges spaced 20 cycles apart, no frame_start -> 17th burst is row 0 (wrap); 3 edges, then frame_start, then an edge -> row 0 streamed.
- Request edge at beat 5 of a burst -> burst unaffected, no extra burst, overrun=1 until the next frame_start pulse, then 0.
- clr asserted at beat 7 -> gm_valid=0 next cycle, busy=1 for 256 cycles, wr_en in that window has no effect (cell reads 9 later), clr_done pulses once.
- wr_en to 0x24 with data 4'h5 in the same cycle beat 4 of row 2 is output -> beat shows 9; next row-2 burst shows 5. Assert rst_n low mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/gm_stream_server_if.sv
// gm_stream_server_if
//   Bundles the game-map traffic of gm_stream_server: the pixel generator's
//   row request and the streamed GMaddress/GMdata beats, the frame and clear
//   pulses, the game-logic cell write port and the status flags.
//   modport slave  : the map server (gm_stream_server).
//   modport master : the clients (pixel generator / game logic / bench).
interface gm_stream_server_if;
  logic       request;
  logic       frame_start;
  logic       clr;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [3:0] wr_data;
  logic [7:0] GMaddress;
  logic [3:0] GMdata;
  logic       gm_valid;
  logic       busy;
  logic       overrun;
  logic       clr_done;

  modport slave (
    input  request, frame_start, clr, wr_en, wr_addr, wr_data,
    output GMaddress, GMdata, gm_valid, busy, overrun, clr_done
  );

  modport master (
    output request, frame_start, clr, wr_en, wr_addr, wr_data,
    input  GMaddress, GMdata, gm_valid, busy, overrun, clr_done
  );
endinterface

// File: rtl/gm_stream_server.sv
// gm_stream_server
//   Holds the 16x16 Minesweeper map (4-bit cell codes) and streams one board
//   row per rising edge of the pixel generator's request as 16 consecutive
//   GMaddress/GMdata beats. Also sweeps the whole map to INIT_CODE on clr.
// Ports:
//   clk   : system clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : gm_stream_server_if.slave
//           in : request, frame_start, clr, wr_en, wr_addr, wr_data
//           out: GMaddress, GMdata, gm_valid, busy, overrun, clr_done
module gm_stream_server #(
  parameter int           COLS      = 16,
  parameter int           ROWS      = 16,
  parameter logic [3:0]   INIT_CODE = 4'h9
) (
  input  logic              clk,
  input  logic              rst_n,
  gm_stream_server_if.slave bus
);

  typedef enum logic [1:0] {IDLE, STREAM, CLEAR} state_t;

  // col wraps in 4 bits, so with COLS=16 the end-of-burst marker is col==0.
  localparam logic [3:0] COL_END  = 4'(COLS);
  localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);
  localparam logic [7:0] CLR_LAST = 8'(COLS * ROWS - 1);

  logic [3:0] mem [256];

  state_t     state;
  logic [3:0] row;
  logic [3:0] col;
  logic       req_q;
  logic       fs_pend;
  logic [7:0] clr_addr;

  logic       req_edge;
  logic       stream_end;
  logic       drop;
  logic [3:0] row_adv;
  logic [3:0] start_row;
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [3:0] mem_wdata;

  assign req_edge   = bus.request & ~req_q;
  assign stream_end = (state == STREAM) && (col == COL_END);
  // The last beat edge of a burst is free to accept a new request.
  assign drop       = req_edge && (((state == STREAM) && !stream_end) || (state == CLEAR));

  always_comb begin
    row_adv = (row == ROW_LAST) ? 4'd0 : row + 4'd1;
    if (fs_pend || bus.frame_start) row_adv = 4'd0;
    start_row = (state == STREAM) ? row_adv : (bus.frame_start ? 4'd0 : row);
  end

  // Map write port: the clear sweep owns the RAM while in CLEAR; clr itself
  // blocks every write in its cycle.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.wr_addr;
    mem_wdata = bus.wr_data;
    if (!bus.clr) begin
      if (state == CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr;
        mem_wdata = INIT_CODE;
      end else if (bus.wr_en) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Control FSM with registered outputs. GMdata reads mem with a
  // non-blocking assignment, so a same-edge write shows the old code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      row           <= 4'd0;
      col           <= 4'd0;
      req_q         <= 1'b0;
      fs_pend       <= 1'b0;
      clr_addr      <= 8'd0;
      bus.GMaddress <= 8'd0;
      bus.GMdata    <= 4'd0;
      bus.gm_valid  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.overrun   <= 1'b0;
      bus.clr_done  <= 1'b0;
    end else begin
      req_q        <= bus.request;
      bus.clr_done <= 1'b0;

      if (bus.frame_start)  bus.overrun <= drop;
      else if (drop)        bus.overrun <= 1'b1;

      if (bus.clr) begin
        state        <= CLEAR;
        bus.busy     <= 1'b1;
        bus.gm_valid <= 1'b0;
        col          <= 4'd0;
        clr_addr     <= 8'd0;
        fs_pend      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (req_edge) begin
              state         <= STREAM;
              bus.busy      <= 1'b1;
              bus.gm_valid  <= 1'b1;
              row           <= start_row;
              col           <= 4'd1;
              bus.GMaddress <= {start_row, 4'd0};
              bus.GMdata    <= mem[{start_row, 4'd0}];
            end else if (bus.frame_start) begin
              row <= 4'd0;
            end
          end
          STREAM: begin
            if (stream_end) begin
              fs_pend <= 1'b0;
              row     <= row_adv;
              if (req_edge) begin
                bus.gm_valid  <= 1'b1;
                col           <= 4'd1;
                bus.GMaddress <= {start_row, 4'd0};
                bus.GMdata    <= mem[{start_row, 4'd0}];
              end else begin
                state        <= IDLE;
                bus.busy     <= 1'b0;
                bus.gm_valid <= 1'b0;
                col          <= 4'd0;
              end
            end else begin
              bus.GMaddress <= {row, col};
              bus.GMdata    <= mem[{row, col}];
              col           <= col + 4'd1;
              if (bus.frame_start) fs_pend <= 1'b1;
            end
          end
          CLEAR: begin
            clr_addr <= clr_addr + 8'd1;
            if (clr_addr == CLR_LAST) begin
              state        <= IDLE;
              bus.busy     <= 1'b0;
              bus.clr_done <= 1'b1;
              row          <= 4'd0;
            end
          end
          default: begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
